// File: rtl/prog_truth_table_unit.sv
// Run-time programmable N_IN-input truth-table evaluator with a registered result
// path and a serially loaded shadow table that commits atomically.
module prog_truth_table_unit #(
    parameter int                   N_IN          = 3,
    parameter logic [(1<<N_IN)-1:0] DEFAULT_TABLE = 8'b1101_0101
) (
    input  logic                   clock,
    input  logic                   reset_b,

    input  logic                   in_valid,
    input  logic [N_IN-1:0]        in_data,
    input  logic                   in_en,
    output logic                   out_valid,
    output logic                   out_e,
    output logic                   out_f,

    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic [(1<<N_IN)-1:0]   table_out
);

    localparam int DEPTH = 1 << N_IN;

    typedef enum logic [1:0] {
        RUN,
        LOAD,
        COMMIT
    } state_t;

    typedef logic [N_IN:0] cnt_t;

    localparam cnt_t LAST_IDX = cnt_t'(DEPTH - 1);

    state_t           state_q,  state_d;
    logic [DEPTH-1:0] table_q,  table_d;
    logic [DEPTH-1:0] shadow_q, shadow_d;
    cnt_t             cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             valid_q;
    logic             e_q;
    logic             f_q;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        table_d  = table_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (cfg_start) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            LOAD: begin
                // A restart wins over a bit offered in the same cycle.
                if (cfg_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cfg_valid) begin
                    shadow_d[cnt_q[N_IN-1:0]] = cfg_bit;
                    cnt_d                     = cnt_q + cnt_t'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                table_d = shadow_q;
                done_d  = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        busy_d = (state_d != RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state_q  <= RUN;
            table_q  <= DEFAULT_TABLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            table_q  <= table_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Evaluation reads table_q, so a result sampled on the commit edge still
    // sees the old table.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            valid_q <= 1'b0;
            e_q     <= 1'b0;
            f_q     <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                e_q <= table_q[in_data];
                f_q <= table_q[in_data] & in_en;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_e     = e_q;
    assign out_f     = f_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign table_out = table_q;

endmodule

// File: tb/tb_prog_truth_table_unit.sv
// Scoreboard bench for prog_truth_table_unit: directed stimulus pushes expected
// results, per-instance monitors pop and compare on out_valid.
module tb_prog_truth_table_unit;

    typedef struct packed {
        logic e;
        logic f;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_b;

    logic        in_valid, in_en, cfg_start, cfg_valid, cfg_bit;
    logic [2:0]  in_data;
    logic        out_valid, out_e, out_f, cfg_busy, cfg_done;
    logic [7:0]  table_out;

    logic        in_valid2, in_en2, cfg_start2, cfg_valid2, cfg_bit2;
    logic [3:0]  in_data2;
    logic        out_valid2, out_e2, out_f2, cfg_busy2, cfg_done2;
    logic [15:0] table_out2;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [7:0]  exp_table;
    logic [15:0] exp_table2;
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;

    always #5 clock = ~clock;

    prog_truth_table_unit dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_e     (out_e),
        .out_f     (out_f),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .table_out (table_out)
    );

    prog_truth_table_unit #(
        .N_IN          (4),
        .DEFAULT_TABLE (16'h8001)
    ) dut4 (
        .clock     (clock),
        .reset_b   (reset_b),
        .in_valid  (in_valid2),
        .in_data   (in_data2),
        .in_en     (in_en2),
        .out_valid (out_valid2),
        .out_e     (out_e2),
        .out_f     (out_f2),
        .cfg_start (cfg_start2),
        .cfg_valid (cfg_valid2),
        .cfg_bit   (cfg_bit2),
        .cfg_busy  (cfg_busy2),
        .cfg_done  (cfg_done2),
        .table_out (table_out2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Inputs driven now are sampled on the coming edge; exp_table is the table
    // that edge must evaluate with.
    task automatic step();
        exp_t x;
        if (reset_b && in_valid) begin
            x = {exp_table[in_data], exp_table[in_data] & in_en};
            q1.push_back(x);
        end
        if (reset_b && in_valid2) begin
            x = {exp_table2[in_data2], exp_table2[in_data2] & in_en2};
            q2.push_back(x);
        end
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t x;
        if (cfg_done === 1'b1) done_cnt++;
        if (out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut3_unexpected_result: out_e %0b with empty scoreboard", out_e);
            end else begin
                x = q1.pop_front();
                check("dut3_out_e", out_e, x.e);
                check("dut3_out_f", out_f, x.f);
            end
        end
        if (out_valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4_unexpected_result: out_e %0b with empty scoreboard", out_e2);
            end else begin
                x = q2.pop_front();
                check("dut4_out_e", out_e2, x.e);
                check("dut4_out_f", out_f2, x.f);
            end
        end
    end

    task automatic start_load();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("busy_after_start", cfg_busy, 1'b1);
    endtask

    // gap idle cycles precede each accepted bit, so the last bit always lands
    // right before the commit cycle.
    task automatic send_bits(input logic [7:0] bits, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            for (int g = 0; g < gap; g++) step();
            cfg_valid = 1'b1;
            cfg_bit   = bits[i];
            step();
            cfg_valid = 1'b0;
        end
    endtask

    task automatic finish_commit(input logic [7:0] t);
        check("busy_in_commit", cfg_busy, 1'b1);
        check("no_done_before_commit", cfg_done, 1'b0);
        check("old_table_in_commit", table_out, exp_table);
        step();
        exp_table = t;
        check("done_pulse", cfg_done, 1'b1);
        check("busy_clear_at_done", cfg_busy, 1'b0);
        check("table_after_commit", table_out, t);
        step();
        check("done_single_cycle", cfg_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        reset_b   = 1'b0;
        in_valid  = 1'b0; in_data  = '0; in_en  = 1'b0;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; in_en2 = 1'b0;
        cfg_start2 = 1'b0; cfg_valid2 = 1'b0; cfg_bit2 = 1'b0;
        exp_table  = 8'hD5;
        exp_table2 = 16'h8001;

        // Reset values
        step(); step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_e", out_e, 1'b0);
        check("rst_out_f", out_f, 1'b0);
        check("rst_cfg_busy", cfg_busy, 1'b0);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_table_out", table_out, 8'hD5);
        check("rst_table_out4", table_out2, 16'h8001);
        reset_b = 1'b1;
        step();

        // Default table sweep: out_e 1,0,1,0,1,0,1,1; then with gating off
        for (int en = 1; en >= 0; en--) begin
            for (int i = 0; i < 8; i++) begin
                in_valid = 1'b1; in_data = 3'(i); in_en = en[0];
                step();
            end
        end
        in_valid = 1'b0;
        step();

        // XOR table load, LSB first
        d0 = done_cnt;
        start_load();
        send_bits(8'h96, 0, 7, 0);
        finish_commit(8'h96);
        check("xor_done_count", done_cnt - d0, 1);
        in_valid = 1'b1; in_en = 1'b1;
        in_data = 3'b011; step();
        in_data = 3'b001; step();
        in_valid = 1'b0;
        step();

        // Continuous evaluation of minterm 7 across a load to 8'h00
        in_valid = 1'b1; in_data = 3'b111; in_en = 1'b1;
        start_load();
        send_bits(8'h00, 0, 7, 0);
        finish_commit(8'h00);
        step(); step();
        in_valid = 1'b0;
        step();

        // Abort mid-load; restart collides with a discarded cfg_valid
        d0 = done_cnt;
        start_load();
        send_bits(8'h00, 0, 4, 0);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b0;
        step();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        check("busy_after_restart", cfg_busy, 1'b1);
        send_bits(8'hFF, 0, 7, 0);
        finish_commit(8'hFF);
        check("abort_done_count", done_cnt - d0, 1);

        // cfg_valid while in RUN is ignored, then a gapped load
        cfg_valid = 1'b1; cfg_bit = 1'b0;
        step(); step(); step();
        cfg_valid = 1'b0;
        check("run_bits_ignored_table", table_out, 8'hFF);
        check("run_bits_ignored_busy", cfg_busy, 1'b0);
        start_load();
        send_bits(8'h3C, 0, 7, 2);
        finish_commit(8'h3C);
        in_valid = 1'b1; in_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 3'(i);
            step();
        end
        in_valid = 1'b0;
        step();

        // Reset in the middle of a load
        d0 = done_cnt;
        start_load();
        send_bits(8'hAA, 0, 3, 0);
        in_valid = 1'b1; in_data = 3'b000;
        reset_b  = 1'b0;
        step();
        in_valid = 1'b0;
        exp_table = 8'hD5;
        check("midload_rst_table", table_out, 8'hD5);
        check("midload_rst_busy", cfg_busy, 1'b0);
        check("midload_rst_out_valid", out_valid, 1'b0);
        reset_b = 1'b1;
        step(); step();
        check("midload_rst_no_done", done_cnt - d0, 0);
        in_valid = 1'b1; in_data = 3'b000; in_en = 1'b1;
        step();
        in_valid = 1'b0;
        step();

        // Four-input instance: only minterms 0 and 15 are true
        for (int i = 0; i < 16; i++) begin
            in_valid2 = 1'b1; in_data2 = 4'(i); in_en2 = 1'b1;
            step();
        end
        in_valid2 = 1'b0;
        step(); step();

        check("scoreboard3_drained", q1.size(), 0);
        check("scoreboard4_drained", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_truth_table_unit.md
Name: prog_truth_table_unit

Overview:
- Parametrised, run-time programmable successor to the fixed 3-input sum-of-minterms primitive and its AND-gated circuit wrapper.
- Evaluates an N_IN-input Boolean function from a 2**N_IN-entry truth-table register, giving registered outputs e = f(inputs) and f = e AND enable.
- Table reloads serially at run time while evaluation continues, and changes over atomically.
- Sits wherever the team previously instantiated fixed truth-table primitives.

Parameters:
- N_IN, 3, number of function inputs (1..6); table depth is 2**N_IN.
- DEFAULT_TABLE, 8'b1101_0101, reset table contents; bit k is f(minterm k); default = Sum(0,2,4,6,7); width 2**N_IN.

Ports:
- clock  in  1  rising-edge clock.
- reset_b  in  1  synchronous, active-low reset.
- in_valid  in  1  evaluation request this cycle.
- in_data  in  N_IN  minterm index; in_data[N_IN-1] is MSB (A in the 3-input case).
- in_en  in  1  gating input for out_f (the d input).
- out_valid  out  1  out_e/out_f valid this cycle.
- out_e  out  1  registered f(in_data).
- out_f  out  1  registered f(in_data) & in_en.
- cfg_start  in  1  begin (or restart) a table load.
- cfg_valid  in  1  cfg_bit is valid this cycle.
- cfg_bit  in  1  serial table bit, minterm 0 first.
- cfg_busy  out  1  load in progress.
- cfg_done  out  1  one-cycle pulse when the new table commits.
- table_out  out  2**N_IN  currently active table.

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-low: sampled only on the rising clock edge.
  - During reset: table = DEFAULT_TABLE, shadow = 0, bit counter = 0, state = RUN.
  - All outputs during reset: out_valid = 0, out_e = 0, out_f = 0, cfg_busy = 0, cfg_done = 0, table_out = DEFAULT_TABLE.
- Evaluation path (independent of the config FSM):
  - Latency is 1 cycle: on the edge where in_valid = 1, out_e <= table[in_data], out_f <= table[in_data] & in_en, out_valid <= 1.
  - When in_valid = 0: out_valid <= 0; out_e and out_f hold their last values.
  - Full throughput: one result per cycle, no backpressure.
- Config FSM states and transitions:
  - RUN -> LOAD on cfg_start = 1: counter <= 0, shadow <= 0, cfg_busy <= 1.
  - In LOAD, each cfg_valid = 1 writes shadow[counter] <= cfg_bit and increments counter. Bits with cfg_valid = 0 are ignored.
  - When the bit at index 2**N_IN-1 is accepted, the next state is COMMIT.
  - COMMIT (one cycle): table <= shadow, cfg_done <= 1 for exactly one cycle, cfg_busy <= 0, then -> RUN.
  - cfg_valid in RUN is ignored.
- Boundary conditions:
  - cfg_start during LOAD aborts the current load. Counter and shadow clear and loading restarts; cfg_busy stays 1. cfg_start has priority over a same-cycle cfg_valid, which is discarded.
  - cfg_start during COMMIT is ignored. The commit completes and the FSM returns to RUN; a new cfg_start is needed afterwards.
  - During LOAD and COMMIT, evaluation uses the old table.
  - An evaluation sampled on the same edge that table is written uses the pre-commit table. The first result using the new table comes from in_valid sampled the cycle after cfg_done asserts.
  - No partial table is ever visible on table_out.
  - Counter width is N_IN+1 bits. Overflow is impossible because the FSM leaves LOAD at 2**N_IN bits.
  - reset_b low mid-load discards the shadow, restores DEFAULT_TABLE and forces RUN. cfg_done does not pulse.

Test Plan:
- Reset, then evaluate: sweep in_data 0..7 with in_en = 1 -> out_e sequence 1,0,1,0,1,0,1,1 one cycle later. Repeat with in_en = 0 -> out_f all 0, out_e unchanged.
- Load the XOR table 8'b1001_0110: 8 cfg_valid bits, LSB first. Required: cfg_busy high from the cycle after cfg_start; cfg_done a single pulse; table_out = 8'h96; in_data = 3'b011 then gives out_e = 0; in_data = 3'b001 gives out_e = 1.
- Continuous evaluation of in_data = 3'b111 across a load to 8'h00 -> out_e = 1 for every result up to and including the commit edge, then 0 from the next one.
- Abort: cfg_start, 5 bits, cfg_start again, 8 bits of 8'hFF -> exactly one cfg_done; table_out = 8'hFF.
- Gapped cfg_valid (every third cycle) and cfg_valid while in RUN -> load completes after exactly 8 accepted bits; bits in RUN leave table_out unchanged.
- Drive reset_b low after 4 load bits -> next cycle table_out = 8'hD5, cfg_busy = 0, out_valid = 0, no cfg_done.
- Repeat with N_IN = 4 and DEFAULT_TABLE = 16'h8001 -> out_e = 1 only for in_data 0 and 15.
